// File: rtl/ex_alu_stage_pkg.sv
// Shared definitions for the execute stage: ALU control encodings (also used by the
// ALU control decoder) and the EX/MEM boundary entry layout.
package ex_alu_stage_pkg;

    localparam int EX_WIDTH    = 32;
    localparam int EX_REG_BITS = 5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_XOR = 2'd2,
        ALU_RSV = 2'd3
    } alu_ctrl_e;

    typedef struct packed {
        logic [EX_WIDTH-1:0]    result;
        logic                   zero;
        logic                   ovf;
        logic                   ill;
        logic [EX_REG_BITS-1:0] rd;
        logic                   rw;
        logic                   mr;
        logic                   mw;
    } ex_entry_t;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU: ADD/SUB/XOR with signed overflow and zero detect; the reserved
// code produces a zero result flagged as illegal.
module ex_alu_stage_alu_core
    import ex_alu_stage_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result   = a + b;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = a - b;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_XOR: result = a ^ b;
            default: illegal = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: computes the ALU result at accept time and holds it in a main/skid
// entry pair at the EX/MEM boundary so that in_ready can come straight from a flop.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
#(
    parameter int WIDTH    = EX_WIDTH,
    parameter int REG_BITS = EX_REG_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          alu_control,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic [REG_BITS-1:0] rd_in,
    input  logic                reg_write_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    alu_result,
    output logic                zero,
    output logic                overflow,
    output logic                illegal_op,
    output logic [REG_BITS-1:0] rd_out,
    output logic                reg_write_out,
    output logic                mem_read_out,
    output logic                mem_write_out
);

    // Handshake: a beat moves on a rising edge only when valid and ready are both high
    // on that side; valid never depends on ready, and flush overrides both sides.
    ex_entry_t main_q, main_d, skid_q, skid_d, new_entry;
    logic      main_v, main_v_d, skid_v, skid_v_d;
    logic      in_ready_q;
    logic      accept, drain;

    logic [WIDTH-1:0] core_result;
    logic             core_zero, core_ovf, core_ill;

    ex_alu_stage_alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .alu_control (alu_control),
        .a           (op_a),
        .b           (op_b),
        .result      (core_result),
        .zero        (core_zero),
        .overflow    (core_ovf),
        .illegal     (core_ill)
    );

    // An illegal op retires as a flagged bubble, so its side-effect enables are cleared.
    always_comb begin
        new_entry.result = core_result;
        new_entry.zero   = core_zero;
        new_entry.ovf    = core_ovf;
        new_entry.ill    = core_ill;
        new_entry.rd     = rd_in;
        new_entry.rw     = reg_write_in && !core_ill;
        new_entry.mr     = mem_read_in  && !core_ill;
        new_entry.mw     = mem_write_in && !core_ill;
    end

    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = main_v && out_ready;

    // in_ready is low whenever the skid holds an entry, so accept implies skid empty.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v;
        skid_v_d = skid_v;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v) begin
            if (drain) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (accept) begin
            if (main_v && !drain) begin
                skid_d   = new_entry;
                skid_v_d = 1'b1;
            end else begin
                main_d   = new_entry;
                main_v_d = 1'b1;
            end
        end else if (drain) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v     <= main_v_d;
            skid_v     <= skid_v_d;
            in_ready_q <= !skid_v_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_v;
    assign alu_result    = main_q.result;
    assign zero          = main_q.zero;
    assign overflow      = main_q.ovf;
    assign illegal_op    = main_q.ill;
    assign rd_out        = main_q.rd;
    assign reg_write_out = main_q.rw;
    assign mem_read_out  = main_q.mr;
    assign mem_write_out = main_q.mw;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: arithmetic corners, back-to-back throughput,
// skid-buffer stall ordering, illegal code, flush and asynchronous reset.
module tb_ex_alu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_control;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_read_in, mem_write_in;
    logic        out_valid, out_ready;
    logic [31:0] alu_result;
    logic        zero, overflow, illegal_op;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_read_out, mem_write_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    ex_alu_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_control   (alu_control),
        .op_a          (op_a),
        .op_b          (op_b),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .zero          (zero),
        .overflow      (overflow),
        .illegal_op    (illegal_op),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .mem_read_out  (mem_read_out),
        .mem_write_out (mem_write_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs are checked there too
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        in_valid     = 1'b1;
        alu_control  = ctl;
        op_a         = a;
        op_b         = b;
        rd_in        = rd;
        reg_write_in = rw;
        mem_read_in  = mr;
        mem_write_in = mw;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, alu_result, exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_result",    alu_result,     32'd0);
        check("rst_flags",     32'({zero, overflow, illegal_op}), 32'd0);
        check("rst_ctl",       32'({rd_out, reg_write_out, mem_read_out, mem_write_out}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD overflow into the sign bit
        drive(2'd0, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("add_valid",  32'(out_valid), 32'd1);
        check("add_result", alu_result,     32'h8000_0000);
        check("add_ovf",    32'(overflow),  32'd1);
        check("add_zero",   32'(zero),      32'd0);
        check("add_rd",     32'(rd_out),    32'd3);
        check("add_rw",     32'(reg_write_out), 32'd1);

        // back-to-back SUB then XOR
        drive(2'd1, 32'd5, 32'd5, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("sub_valid",  32'(out_valid), 32'd1);
        check("sub_result", alu_result,     32'd0);
        check("sub_zero",   32'(zero),      32'd1);
        check("sub_ovf",    32'(overflow),  32'd0);
        drive(2'd2, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5, 1'b0, 1'b0, 1'b1);
        tick();
        check("xor_valid",  32'(out_valid), 32'd1);
        check("xor_result", alu_result,     32'h0000_FF00);
        check("xor_zero",   32'(zero),      32'd0);
        check("xor_mw",     32'(mem_write_out), 32'd1);
        // SUB signed overflow: most-negative minus one
        drive(2'd1, 32'h8000_0000, 32'h1, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        check("subov_result", alu_result,    32'h7FFF_FFFF);
        check("subov_ovf",    32'(overflow), 32'd1);
        idle();
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // stall: three ops with out_ready low, then release
        out_ready = 1'b0;
        drive(2'd0, 32'd1, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'd3);
        tick();
        check("stall_a_ready", 32'(in_ready),  32'd1);
        check("stall_a_valid", 32'(out_valid), 32'd1);
        drive(2'd1, 32'd10, 32'd3, 5'd8, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'd7);
        tick();
        check("stall_b_ready",  32'(in_ready), 32'd0);
        check("stall_b_result", alu_result,    32'd3);
        drive(2'd2, 32'h0000_00FF, 32'h0000_000F, 5'd9, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'h0000_00F0);
        tick();
        check("stall_c_ready",  32'(in_ready), 32'd0);
        check("stall_c_hold",   alu_result,    32'd3);
        check("stall_c_rd",     32'(rd_out),   32'd7);
        out_ready = 1'b1;
        pop_check("stall_res0");
        tick();
        check("rel_b_ready", 32'(in_ready), 32'd1);
        check("rel_b_rd",    32'(rd_out),   32'd8);
        pop_check("stall_res1");
        tick();
        check("rel_c_valid", 32'(out_valid), 32'd1);
        check("rel_c_rd",    32'(rd_out),    32'd9);
        pop_check("stall_res2");
        idle();
        tick();
        check("rel_empty",    32'(out_valid), 32'd0);
        check("rel_queue",    32'(exp_q.size()), 32'd0);

        // reserved code with all side-effect enables requested
        drive(2'd3, 32'd5, 32'd6, 5'd10, 1'b1, 1'b1, 1'b1);
        tick();
        check("ill_flag",   32'(illegal_op), 32'd1);
        check("ill_result", alu_result,      32'd0);
        check("ill_zero",   32'(zero),       32'd1);
        check("ill_ovf",    32'(overflow),   32'd0);
        check("ill_en",     32'({reg_write_out, mem_read_out, mem_write_out}), 32'd0);
        idle();
        tick();

        // flush with both entries full and an op presented
        out_ready = 1'b0;
        drive(2'd0, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2'd0, 32'd2, 32'd2, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        check("fl_pre_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(2'd0, 32'd3, 32'd3, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready),  32'd1);
        tick();
        check("fl_no_accept", 32'(out_valid), 32'd0);

        // asynchronous reset during a stall
        drive(2'd0, 32'd20, 32'd22, 5'd14, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        check("ar_pre_result", alu_result,    32'd42);
        #2 reset = 1'b1;
        #1;
        check("ar_valid",  32'(out_valid), 32'd0);
        check("ar_result", alu_result,     32'd0);
        check("ar_ready",  32'(in_ready),  32'd1);
        check("ar_ctl",    32'({rd_out, reg_write_out, mem_read_out}), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ar_after_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
